rx_sample_packer: RTL and testbench
===================================

Name: rx_sample_packer

Overview:
- Sits directly downstream of the per-channel DDCs in the RX path.
- Consumes decimated I/Q samples qualified by the DDC output strobe. Serialises one sample set, covering all channels, into a 16-bit FIFO write stream for the RX buffer.
- Supports 16-bit I/Q words or 8-bit packed I/Q. Flags overrun when the FIFO cannot keep up with the strobe rate.

Parameters:
- NCH, 2, number of DDC channels packed per sample set (1..4).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  block enable; low aborts any emission and holds the block idle
- width8  in  1  0 = 16-bit mode (2 words per channel), 1 = 8-bit mode (1 word per channel); sampled only on accepted strobe
- strobe_in  in  1  one-cycle sample-valid from the DDC (strobe)
- i_in  in  16*NCH  channel c I at bits [16c+15:16c]
- q_in  in  16*NCH  channel c Q, same layout
- fifo_full  in  1  downstream FIFO full
- fifo_wr  out  1  write request; a word is written on every cycle where this is 1
- fifo_data  out  16  write data
- busy  out  1  emission in progress
- overrun  out  1  sticky overrun flag
- clear_overrun  in  1  clears overrun

Behaviour:
- Reset values: state IDLE, idx 0, fifo_wr 0, fifo_data 0, busy 0, overrun 0, holding registers 0.
- Decisions are made on the registered state. fifo_wr and fifo_data are combinational decodes of state, idx and the holding registers; there is no comb path from strobe_in.
- Sample accept: strobe_in & enable while IDLE, or in the final-write cycle of EMIT.
  - Latch i_in, q_in and width8 into the holding registers.
  - Set idx=0 and go to EMIT.
  - Word count W = 2*NCH (16-bit mode) or NCH (8-bit mode).
- EMIT: fifo_wr = ~fifo_full.
  - On a write cycle idx increments.
  - When idx==W-1 and the write occurs, go to IDLE, unless a strobe is accepted in that same cycle (back-to-back, no gap, no overrun).
  - fifo_full stalls emission indefinitely with no data loss for the current set.
- Word order, 16-bit mode: ch0 I, ch0 Q, ch1 I, ch1 Q, ...
- Word order, 8-bit mode: word c = {I_c[15:8], Q_c[15:8]}, truncation with no rounding, I in the high byte.
- Latency: strobe accepted at edge t puts the first fifo_wr at cycle t+1 if not full. An unstalled set completes in W cycles.
- Overrun:
  - Set when strobe_in & enable arrives in EMIT other than in the final-write cycle. The new sample is dropped and the current set continues intact.
  - clear_overrun clears it. If set and clear occur in the same cycle, set wins.
- busy = (state==EMIT).
- enable low at any time: next state IDLE, idx 0, partial set abandoned (downstream framing is the host's concern), overrun retained.
- reset mid-emission: everything returns to reset values on the next edge; no further writes.
- strobe_in while enable=0: ignored, no overrun.

Decomposition:
- Shared package holds state encodings (ST_IDLE, ST_EMIT), the word width constant (16) and the MAX_NCH=4 limit.
- One natural sub-module: rx_word_mux. It is purely combinational: it selects fifo_data from the holding registers given idx and mode.
- The FSM, counter and overrun logic stay in the top module.

Test Plan:
- NCH=2, width8=0, fifo_full=0, one strobe with ch0 I=0x1234, Q=0x5678, ch1 I=0x9ABC, Q=0xDEF0 -> fifo_wr high for 4 consecutive cycles starting t+1, data 1234,5678,9ABC,DEF0. busy falls after the 4th; overrun=0.
- width8=1, same samples -> 2 writes: 0x1256, 0x9ADE.
- 16-bit mode, fifo_full held high for cycles t+2..t+5 -> writes 1234 at t+1, stall, 5678/9ABC/DEF0 at t+6..t+8; no loss, overrun=0.
- Strobe exactly in the final-write cycle, then a second strobe 2 cycles after the first -> the first back-to-back set is written with no gap, overrun=0. The second strobe raises overrun; that sample is absent from the stream.
- Overrun set, then clear_overrun asserted in the same cycle as a new overrun event -> overrun stays 1; clear alone one cycle later -> 0.
- Deassert enable after 2 of 4 words -> fifo_wr low next cycle, busy 0. Overrun unchanged. A strobe while disabled produces no writes. Reset mid-emission gives all outputs 0 next cycle.

Source files
------------

// File: rtl/rx_sample_packer_pkg.sv
// Shared types and constants for the RX sample packer: FSM encoding,
// FIFO word width and the channel-count limit.
package rx_sample_packer_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    localparam int WORD_W  = 16;
    localparam int MAX_NCH = 4;
    // Enough to index the longest set: 2*MAX_NCH words.
    localparam int IDX_W   = 3;

endpackage

// File: rtl/rx_word_mux.sv
// Combinational word selector: picks the FIFO word for position idx of the
// held sample set, in 16-bit (I,Q per channel) or 8-bit packed mode.
module rx_word_mux
    import rx_sample_packer_pkg::*;
#(
    parameter int NCH = 2
) (
    input  logic [16*NCH-1:0] i_i,
    input  logic [16*NCH-1:0] q_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic              width8_i,
    output logic [WORD_W-1:0] data_o
);

    always_comb begin
        data_o = '0;
        for (int c = 0; c < NCH; c++) begin
            if (width8_i) begin
                // Truncate to the top byte of each component, I in the high byte.
                if (idx_i == IDX_W'(c))
                    data_o = {i_i[16*c+8 +: 8], q_i[16*c+8 +: 8]};
            end else begin
                if (idx_i == IDX_W'(2*c))
                    data_o = i_i[16*c +: 16];
                else if (idx_i == IDX_W'(2*c+1))
                    data_o = q_i[16*c +: 16];
            end
        end
    end

endmodule

// File: rtl/rx_sample_packer.sv
// Serialises one DDC sample set (all channels) into a 16-bit FIFO write
// stream, with back-to-back acceptance on the final write and sticky overrun.
module rx_sample_packer
    import rx_sample_packer_pkg::*;
#(
    parameter int NCH = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              width8,
    input  logic              strobe_in,
    input  logic [16*NCH-1:0] i_in,
    input  logic [16*NCH-1:0] q_in,
    input  logic              fifo_full,
    output logic              fifo_wr,
    output logic [WORD_W-1:0] fifo_data,
    output logic              busy,
    output logic              overrun,
    input  logic              clear_overrun,
    output state_t            dbg_state
);

    localparam logic [IDX_W-1:0] LAST16 = IDX_W'(2*NCH-1);
    localparam logic [IDX_W-1:0] LAST8  = IDX_W'(NCH-1);

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [16*NCH-1:0] hold_i_q, hold_i_d;
    logic [16*NCH-1:0] hold_q_q, hold_q_d;
    logic              hold_w8_q, hold_w8_d;
    logic              overrun_q, overrun_d;

    logic              emit;
    logic              wr;
    logic              final_wr;
    logic              accept;
    logic              ovr_set;
    logic [WORD_W-1:0] mux_data;

    // Control decisions depend only on registered state plus fifo_full/strobe.
    assign emit     = (state_q == ST_EMIT);
    assign wr       = emit & ~fifo_full;
    assign final_wr = wr & (idx_q == (hold_w8_q ? LAST8 : LAST16));
    assign accept   = strobe_in & enable & (~emit | final_wr);
    assign ovr_set  = strobe_in & enable & emit & ~final_wr;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            hold_i_q  <= '0;
            hold_q_q  <= '0;
            hold_w8_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            hold_i_q  <= hold_i_d;
            hold_q_q  <= hold_q_d;
            hold_w8_q <= hold_w8_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        hold_i_d  = hold_i_q;
        hold_q_d  = hold_q_q;
        hold_w8_d = hold_w8_q;
        if (!enable) begin
            state_d = ST_IDLE;
            idx_d   = '0;
        end else if (accept) begin
            state_d   = ST_EMIT;
            idx_d     = '0;
            hold_i_d  = i_in;
            hold_q_d  = q_in;
            hold_w8_d = width8;
        end else if (final_wr) begin
            state_d = ST_IDLE;
            idx_d   = '0;
        end else if (wr) begin
            idx_d = idx_q + IDX_W'(1);
        end

        // Set beats clear when both happen in the same cycle.
        if (ovr_set)
            overrun_d = 1'b1;
        else if (clear_overrun)
            overrun_d = 1'b0;
        else
            overrun_d = overrun_q;
    end

    rx_word_mux #(.NCH(NCH)) u_mux (
        .i_i      (hold_i_q),
        .q_i      (hold_q_q),
        .idx_i    (idx_q),
        .width8_i (hold_w8_q),
        .data_o   (mux_data)
    );

    always_comb begin
        fifo_wr   = wr;
        fifo_data = emit ? mux_data : '0;
        busy      = emit;
        overrun   = overrun_q;
        dbg_state = state_q;
    end

endmodule

// File: tb/tb_rx_sample_packer.sv
// Bench for rx_sample_packer (NCH=2): directed scenarios then random traffic,
// checked cycle by cycle against a queue-based model of the pending words.
module tb_rx_sample_packer;
    import rx_sample_packer_pkg::*;

    localparam int NCH = 2;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              enable = 1'b0;
    logic              width8 = 1'b0;
    logic              strobe_in = 1'b0;
    logic [16*NCH-1:0] i_in = '0;
    logic [16*NCH-1:0] q_in = '0;
    logic              fifo_full = 1'b0;
    logic              fifo_wr;
    logic [15:0]       fifo_data;
    logic              busy;
    logic              overrun;
    logic              clear_overrun = 1'b0;
    state_t            dbg_state;

    int total = 0;
    int bad   = 0;

    // Reference model: words still owed for the current set, and the flag.
    logic [15:0] cur_q[$];
    logic        exp_ov = 1'b0;
    logic [15:0] wr_log[$];

    rx_sample_packer #(.NCH(NCH)) dut (
        .clock         (clock),
        .reset         (reset),
        .enable        (enable),
        .width8        (width8),
        .strobe_in     (strobe_in),
        .i_in          (i_in),
        .q_in          (q_in),
        .fifo_full     (fifo_full),
        .fifo_wr       (fifo_wr),
        .fifo_data     (fifo_data),
        .busy          (busy),
        .overrun       (overrun),
        .clear_overrun (clear_overrun),
        .dbg_state     (dbg_state)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic build_set(input logic w8, input logic [31:0] iv, input logic [31:0] qv);
        for (int c = 0; c < NCH; c++) begin
            if (w8) begin
                cur_q.push_back({iv[16*c+8 +: 8], qv[16*c+8 +: 8]});
            end else begin
                cur_q.push_back(iv[16*c +: 16]);
                cur_q.push_back(qv[16*c +: 16]);
            end
        end
    endtask

    // One clock cycle: drive inputs at negedge, check outputs, advance model.
    task automatic step(input logic stb, input logic w8, input logic full, input logic en,
                        input logic clr, input logic rst,
                        input logic [31:0] iv, input logic [31:0] qv);
        logic busy_e, wr_e, final_e, set_e;
        @(negedge clock);
        strobe_in = stb; width8 = w8; fifo_full = full; enable = en;
        clear_overrun = clr; reset = rst; i_in = iv; q_in = qv;
        #1;
        busy_e = (cur_q.size() != 0);
        wr_e   = busy_e && !full;
        chk("busy", 16'(busy), 16'(busy_e));
        chk("state", 16'(dbg_state == ST_EMIT), 16'(busy_e));
        chk("fifo_wr", 16'(fifo_wr), 16'(wr_e));
        chk("fifo_data", fifo_data, busy_e ? cur_q[0] : 16'h0000);
        chk("overrun", 16'(overrun), 16'(exp_ov));
        if (fifo_wr === 1'b1) wr_log.push_back(fifo_data);
        if (rst) begin
            cur_q.delete();
            exp_ov = 1'b0;
        end else begin
            final_e = wr_e && (cur_q.size() == 1);
            set_e   = en && stb && busy_e && !final_e;
            if (!en) begin
                cur_q.delete();
            end else begin
                if (wr_e) void'(cur_q.pop_front());
                if (stb && (!busy_e || final_e)) build_set(w8, iv, qv);
            end
            if (set_e) exp_ov = 1'b1;
            else if (clr) exp_ov = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 1, 0, 0, '0, '0);
    endtask

    task automatic chk_log(input string tag, input logic [15:0] exp_words[$]);
        chk({tag, "_len"}, 16'(wr_log.size()), 16'(exp_words.size()));
        for (int k = 0; k < exp_words.size() && k < wr_log.size(); k++)
            chk(tag, wr_log[k], exp_words[k]);
        wr_log.delete();
    endtask

    localparam logic [31:0] IA = 32'h9ABC_1234;
    localparam logic [31:0] QA = 32'hDEF0_5678;
    localparam logic [31:0] IB = 32'hAAAA_1111;
    localparam logic [31:0] QB = 32'hBBBB_2222;
    localparam logic [31:0] IC = 32'hCCCC_3333;
    localparam logic [31:0] QC = 32'hDDDD_4444;

    initial begin
        // Flush X out of the DUT before the first checked cycle.
        repeat (2) @(posedge clock);
        step(0, 0, 0, 0, 0, 1, '0, '0);
        wr_log.delete();

        // 16-bit mode, single set.
        step(1, 0, 0, 1, 0, 0, IA, QA);
        idle(6);
        chk_log("set16", '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0});

        // 8-bit packed mode.
        step(1, 1, 0, 1, 0, 0, IA, QA);
        idle(4);
        chk_log("set8", '{16'h1256, 16'h9ADE});

        // Stall for four cycles after the first word.
        step(1, 0, 0, 1, 0, 0, IA, QA);
        step(0, 0, 0, 1, 0, 0, '0, '0);
        for (int k = 0; k < 4; k++) step(0, 0, 1, 1, 0, 0, '0, '0);
        idle(5);
        chk_log("stall", '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0});

        // Back-to-back on the final write, then an overrunning strobe.
        step(1, 0, 0, 1, 0, 0, IA, QA);
        idle(3);
        step(1, 0, 0, 1, 0, 0, IB, QB);
        idle(1);
        step(1, 0, 0, 1, 0, 0, IC, QC);
        idle(5);
        chk("ovr_b2b", 16'(overrun), 16'h0001);
        chk_log("b2b", '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0,
                         16'h1111, 16'h2222, 16'hAAAA, 16'hBBBB});

        // Set and clear in the same cycle: set wins; clear alone then drops it.
        step(1, 0, 0, 1, 0, 0, IA, QA);
        step(1, 0, 0, 1, 1, 0, IB, QB);
        step(0, 0, 0, 1, 0, 0, '0, '0);
        chk("ovr_setwins", 16'(overrun), 16'h0001);
        step(0, 0, 0, 1, 1, 0, '0, '0);
        step(0, 0, 0, 1, 0, 0, '0, '0);
        chk("ovr_clear", 16'(overrun), 16'h0000);
        idle(4);
        wr_log.delete();

        // Disable after two words, strobe while disabled, reset mid-emission.
        step(1, 0, 0, 1, 0, 0, IA, QA);
        step(0, 0, 0, 1, 0, 0, '0, '0);
        step(0, 0, 0, 1, 0, 0, '0, '0);
        step(0, 0, 0, 0, 0, 0, '0, '0);
        step(1, 0, 0, 0, 0, 0, IB, QB);
        step(0, 0, 0, 0, 0, 0, '0, '0);
        chk("dis_busy", 16'(busy), 16'h0000);
        chk_log("disable", '{16'h1234, 16'h5678, 16'h9ABC});
        step(1, 0, 0, 1, 0, 0, IA, QA);
        step(0, 0, 0, 1, 0, 1, '0, '0);
        step(0, 0, 0, 1, 0, 0, '0, '0);
        chk("rst_wr", 16'(fifo_wr), 16'h0000);
        chk("rst_data", fifo_data, 16'h0000);

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 3) == 0, $urandom_range(0, 19) != 0,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 99) == 0,
                 $urandom, $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
